// File: rtl/fifo_uart_drain_if.sv
// FIFO read-port bundle between the 16x8 FIFO and its UART drain.
// The master side owns the pop strobe; the slave side is the FIFO.
interface fifo_uart_drain_if;
   logic       fifo_empty;
   logic       fifo_wr;
   logic [7:0] fifo_data;
   logic       fifo_rd;

   modport master (
      input  fifo_empty,
      input  fifo_wr,
      input  fifo_data,
      output fifo_rd
   );

   modport slave (
      output fifo_empty,
      output fifo_wr,
      output fifo_data,
      input  fifo_rd
   );
endinterface

// File: rtl/fifo_uart_drain.sv
// Pops one byte at a time from the FIFO and shifts it out as a UART frame
// (start, 8 data LSB first, optional even parity, stop); counts completed frames.
module fifo_uart_drain #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_EN    = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   fifo_uart_drain_if.master        fifo,
   input  logic                     tx_en,
   output logic                     tx,
   output logic                     busy,
   output logic [15:0]              byte_cnt
);

   typedef enum logic [2:0] {
      IDLE, POP, LOAD, START, DATA, PARITY, STOP
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state_q;
   logic [15:0] baud_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic        parity_q;
   logic        dropped_q;
   logic        tx_q;
   logic        rd_q;
   logic        busy_q;
   logic [15:0] cnt_q;
   logic        baud_done;

   assign baud_done = (baud_q == BAUD_LAST);

   assign fifo.fifo_rd = rd_q;
   assign tx           = tx_q;
   assign busy         = busy_q;
   assign byte_cnt     = cnt_q;

   // NOTE: every register here is updated with <= so all decisions see pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         baud_q    <= 16'd0;
         bit_q     <= 3'd0;
         shift_q   <= 8'd0;
         parity_q  <= 1'b0;
         dropped_q <= 1'b0;
         tx_q      <= 1'b1;
         rd_q      <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= 16'd0;
      end else begin
         rd_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tx_en && !fifo.fifo_empty) begin
                  state_q <= POP;
                  rd_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            POP: begin
               // A concurrent write or an empty FIFO means the FIFO ignored our pop.
               dropped_q <= fifo.fifo_wr | fifo.fifo_empty;
               state_q   <= LOAD;
            end
            LOAD: begin
               if (dropped_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  shift_q  <= fifo.fifo_data;
                  parity_q <= ^fifo.fifo_data;
                  tx_q     <= 1'b0;
                  baud_q   <= 16'd0;
                  state_q  <= START;
               end
            end
            START: begin
               if (baud_done) begin
                  baud_q  <= 16'd0;
                  bit_q   <= 3'd0;
                  tx_q    <= shift_q[0];
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_q <= 16'd0;
                  if (bit_q == 3'd7) begin
                     if (PARITY_EN) begin
                        tx_q    <= parity_q;
                        state_q <= PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                     end
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            PARITY: begin
               if (baud_done) begin
                  baud_q  <= 16'd0;
                  tx_q    <= 1'b1;
                  state_q <= STOP;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud_q  <= 16'd0;
                  cnt_q   <= cnt_q + 16'd1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  baud_q <= baud_q + 16'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain: two instances at 4 clocks/bit, one
// without and one with parity, each fed by a small behavioural FIFO.
module tb_fifo_uart_drain;

   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;
      int          nbits;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_en0, tx_en1;
   logic        tx0, tx1, busy0, busy1;
   logic [15:0] cnt0, cnt1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rd_cnt0  = 0;
   int rd_cnt1  = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   frame_t     vecs[10];

   fifo_uart_drain_if ifc0 ();
   fifo_uart_drain_if ifc1 ();

   fifo_uart_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
      .clk      (clk),
      .rst      (rst),
      .fifo     (ifc0),
      .tx_en    (tx_en0),
      .tx       (tx0),
      .busy     (busy0),
      .byte_cnt (cnt0)
   );

   fifo_uart_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .fifo     (ifc1),
      .tx_en    (tx_en1),
      .tx       (tx1),
      .busy     (busy1),
      .byte_cnt (cnt1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Behavioural FIFOs: write wins over read, data valid the cycle after a pop.
   always @(posedge clk) begin
      logic [7:0] b;
      if (ifc0.fifo_rd === 1'b1 && ifc0.fifo_empty === 1'b0 && ifc0.fifo_wr === 1'b0) begin
         b = q0.pop_front();
         ifc0.fifo_data <= b;
      end
      ifc0.fifo_empty <= (q0.size() == 0);
   end

   always @(posedge clk) begin
      logic [7:0] b;
      if (ifc1.fifo_rd === 1'b1 && ifc1.fifo_empty === 1'b0 && ifc1.fifo_wr === 1'b0) begin
         b = q1.pop_front();
         ifc1.fifo_data <= b;
      end
      ifc1.fifo_empty <= (q1.size() == 0);
   end

   always @(negedge clk) begin
      if (ifc0.fifo_rd === 1'b1) rd_cnt0++;
      if (ifc1.fifo_rd === 1'b1) rd_cnt1++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic get_tx(input int sel);
      return (sel != 0) ? tx1 : tx0;
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel != 0) ? busy1 : busy0;
   endfunction

   // Samples until the start bit appears; gap = high samples seen before it.
   task automatic wait_start(input int sel, output int gap);
      logic seen;
      seen = 1'b0;
      gap  = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (get_tx(sel) == 1'b0) begin
            seen = 1'b1;
            break;
         end
         gap++;
      end
      check("start_seen", seen, 1'b1);
   endtask

   // Called right after wait_start has seen the first start-bit sample.
   task automatic check_frame(input int sel, input logic [10:0] bits, input int nbits, input string name);
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < 4; c++) begin
            if (b == 0 && c == 0) continue;
            @(posedge clk); #1;
            check($sformatf("%s_bit%0d", name, b), get_tx(sel), bits[b]);
            if (c == 1) check($sformatf("%s_busy%0d", name, b), get_busy(sel), 1'b1);
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      @(negedge clk) rst = 1'b1;
   endtask

   initial begin
      int gap;
      int base;
      int c1;
      int sz;
      logic found;

      // frame[0]=start, frame[8:1]=data LSB first, then parity (if any) and stop
      vecs[0] = '{8'hA5, 11'b0_1_1010_0101_0, 10};
      vecs[1] = '{8'h00, 11'b0_1_0000_0000_0, 10};
      vecs[2] = '{8'hFF, 11'b0_1_1111_1111_0, 10};
      vecs[3] = '{8'h3C, 11'b0_1_0011_1100_0, 10};
      vecs[4] = '{8'h07, 11'b1_1_0000_0111_0, 11};
      vecs[5] = '{8'h03, 11'b1_0_0000_0011_0, 11};
      vecs[6] = '{8'h81, 11'b1_0_1000_0001_0, 11};
      vecs[7] = '{8'hC3, 11'b0_1_1100_0011_0, 10};
      vecs[8] = '{8'h96, 11'b0_1_1001_0110_0, 10};
      vecs[9] = '{8'h2D, 11'b0_1_0010_1101_0, 10};

      rst          = 1'b0;
      tx_en0       = 1'b1;
      tx_en1       = 1'b0;
      ifc0.fifo_wr = 1'b0;
      ifc1.fifo_wr = 1'b0;
      q0.push_back(vecs[0].data);

      // Reset held with a non-empty FIFO, then a single byte
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rst_tx", tx0, 1'b1);
         check("rst_rd", ifc0.fifo_rd, 1'b0);
         check("rst_busy", busy0, 1'b0);
         check("rst_cnt", cnt0, 16'd0);
      end
      @(negedge clk) rst = 1'b1;
      #1 check("rd_at_release", ifc0.fifo_rd, 1'b0);
      @(posedge clk); #1;
      check("rd_first_pop", ifc0.fifo_rd, 1'b1);
      check("busy_in_pop", busy0, 1'b1);
      wait_start(0, gap);
      check("load_gap", gap, 1);
      check_frame(0, vecs[0].frame, vecs[0].nbits, "single");
      @(posedge clk); #1;
      check("single_end_busy", busy0, 1'b0);
      check("single_end_tx", tx0, 1'b1);
      check("single_cnt", cnt0, 16'd1);
      check("single_rd_pulses", rd_cnt0, 1);

      // Dropped pop: write collides with the pop cycle
      pulse_reset();
      base = rd_cnt0;
      q0.push_back(vecs[7].data);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ifc0.fifo_rd === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("drop_first_rd", found, 1'b1);
      c1 = cyc;
      sz = q0.size();
      ifc0.fifo_wr = 1'b1;
      @(negedge clk) ifc0.fifo_wr = 1'b0;
      check("drop_no_pop", q0.size(), sz);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ifc0.fifo_rd === 1'b1) begin
            found = 1'b1;
            break;
         end
         check("drop_no_start", tx0, 1'b1);
      end
      check("drop_retry_rd", found, 1'b1);
      check("drop_retry_gap", cyc - c1, 3);
      wait_start(0, gap);
      check_frame(0, vecs[7].frame, vecs[7].nbits, "drop");
      @(posedge clk); #1;
      check("drop_cnt", cnt0, 16'd1);
      check("drop_rd_pulses", rd_cnt0 - base, 2);

      // Back-to-back frames
      pulse_reset();
      base = rd_cnt0;
      for (int k = 1; k <= 3; k++) q0.push_back(vecs[k].data);
      for (int k = 1; k <= 3; k++) begin
         wait_start(0, gap);
         if (k > 1) check("b2b_gap", gap, 3);
         check_frame(0, vecs[k].frame, vecs[k].nbits, $sformatf("b2b%0d", k));
      end
      repeat (5) @(posedge clk);
      #1;
      check("b2b_cnt", cnt0, 16'd3);
      check("b2b_rd_pulses", rd_cnt0 - base, 3);
      check("b2b_idle_busy", busy0, 1'b0);

      // Parity frames, then tx_en dropped mid-frame
      tx_en1 = 1'b1;
      q1.push_back(vecs[4].data);
      q1.push_back(vecs[5].data);
      for (int k = 4; k <= 5; k++) begin
         wait_start(1, gap);
         if (k > 4) check("par_gap", gap, 3);
         check_frame(1, vecs[k].frame, vecs[k].nbits, $sformatf("par%0d", k));
      end
      @(posedge clk); #1;
      check("par_end_busy", busy1, 1'b0);
      check("par_cnt", cnt1, 16'd2);
      q1.push_back(vecs[6].data);
      q1.push_back(8'h42);
      wait_start(1, gap);
      tx_en1 = 1'b0;
      base = rd_cnt1;
      check_frame(1, vecs[6].frame, vecs[6].nbits, "txen");
      repeat (20) @(posedge clk);
      #1;
      check("txen_no_rd", rd_cnt1 - base, 0);
      check("txen_fifo_left", q1.size(), 1);
      check("txen_busy", busy1, 1'b0);
      check("txen_tx", tx1, 1'b1);
      check("txen_cnt", cnt1, 16'd3);

      // Reset during DATA bit 3
      q0.push_back(vecs[8].data);
      q0.push_back(vecs[9].data);
      wait_start(0, gap);
      repeat (17) begin
         @(posedge clk); #1;
      end
      check("mid_bit3_tx", tx0, vecs[8].frame[4]);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_tx", tx0, 1'b1);
      check("mid_rst_rd", ifc0.fifo_rd, 1'b0);
      check("mid_rst_busy", busy0, 1'b0);
      check("mid_rst_cnt", cnt0, 16'd0);
      @(negedge clk);
      @(negedge clk) rst = 1'b1;
      wait_start(0, gap);
      check_frame(0, vecs[9].frame, vecs[9].nbits, "after_rst");
      @(posedge clk); #1;
      check("after_rst_cnt", cnt0, 16'd1);
      check("after_rst_fifo", q0.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
